// File: rtl/pcs_10g_gearbox_tx.sv
// rtl/pcs_10g_gearbox_tx.sv - 66b-to-64b transmit gearbox feeding the 10GBASE-R PMA serializer
// Packs 32 blocks into 33 words; the residual buffer is flushed when the sequence count reaches 32.
module pcs_10g_gearbox_tx #(
  parameter int DATA_W = 64,
  parameter int HEAD_W = 2,
  parameter int SEQ_W  = 6
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              valid_i,
  input  logic [HEAD_W-1:0] head_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [SEQ_W-1:0]  seq_o
);

  localparam int BLK_W = DATA_W + HEAD_W;
  localparam int CAT_W = 2 * DATA_W;
  localparam int SH_W  = $clog2(CAT_W);
  localparam int N_BLK = DATA_W / HEAD_W;
  localparam logic [SEQ_W-1:0] FLUSH_SEQ = SEQ_W'(N_BLK);

  logic [SEQ_W-1:0]  r_seq;
  logic [DATA_W-1:0] r_buf;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;

  logic              w_is_flush;
  logic              w_accept;
  logic [SH_W-1:0]   w_shift;
  logic [BLK_W-1:0]  w_blk;
  logic [CAT_W-1:0]  w_cat;
  logic [SEQ_W-1:0]  w_seq_nxt;
  logic [DATA_W-1:0] w_buf_nxt;
  logic [DATA_W-1:0] w_data_nxt;
  logic              w_valid_nxt;

  // Out-of-range counts fall into FLUSH so the machine always recovers to 0.
  assign w_is_flush = (r_seq >= FLUSH_SEQ);
  assign w_accept   = valid_i & ~w_is_flush;

  assign w_blk   = {data_i, head_i};
  assign w_shift = SH_W'(r_seq) * SH_W'(HEAD_W);
  // Residual bits above 2*seq are kept at zero, so an OR merges them with the shifted block.
  assign w_cat   = (CAT_W'(w_blk) << w_shift) | CAT_W'(r_buf);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_seq   <= '0;
      r_buf   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_seq   <= w_seq_nxt;
      r_buf   <= w_buf_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  always_comb begin
    w_seq_nxt = r_seq;
    w_buf_nxt = r_buf;
    if (w_is_flush) begin
      w_seq_nxt = '0;
      w_buf_nxt = '0;
    end else if (w_accept) begin
      w_seq_nxt = r_seq + SEQ_W'(1);
      w_buf_nxt = w_cat[CAT_W-1:DATA_W];
    end
  end

  always_comb begin
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    if (w_is_flush) begin
      w_data_nxt  = r_buf;
      w_valid_nxt = 1'b1;
    end else if (w_accept) begin
      w_data_nxt  = w_cat[DATA_W-1:0];
      w_valid_nxt = 1'b1;
    end
  end

  assign ready_o = ~w_is_flush;
  assign valid_o = r_valid;
  assign data_o  = r_data;
  assign seq_o   = r_seq;

endmodule

// File: tb/tb_pcs_10g_gearbox_tx.sv
// tb/tb_pcs_10g_gearbox_tx.sv - self-checking bench for pcs_10g_gearbox_tx
// Bit-serial scoreboard plus table vectors and hand-written corner sequences.
module tb_pcs_10g_gearbox_tx;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        valid_i = 1'b0;
  logic [1:0]  head_i = 2'b00;
  logic [63:0] data_i = 64'd0;
  logic        ready_o;
  logic        valid_o;
  logic [63:0] data_o;
  logic [5:0]  seq_o;

  pcs_10g_gearbox_tx #(.DATA_W(64), .HEAD_W(2), .SEQ_W(6)) dut (
    .clk     (clk),
    .nreset  (nreset),
    .valid_i (valid_i),
    .head_i  (head_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .data_o  (data_o),
    .seq_o   (seq_o)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  bit          sb_q[$];
  int          exp_seq = 0;
  logic [63:0] prev_data = 64'd0;
  logic [63:0] mon_w;
  logic [65:0] mon_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // Scoreboard: inputs are stable at negedge, so a push here is the block taken at the next posedge.
  always @(negedge clk) begin
    if (!nreset) begin
      sb_q.delete();
      exp_seq = 0;
      prev_data = 64'd0;
    end else begin
      check("seq_o", 64'(seq_o), 64'(exp_seq));
      check("ready_o", 64'(ready_o), 64'(exp_seq != 32));
      if (valid_o) begin
        if (sb_q.size() < 64) begin
          check("sb_underflow", 64'(sb_q.size()), 64'd64);
        end else begin
          for (int i = 0; i < 64; i++) mon_w[i] = sb_q.pop_front();
          check("stream_word", data_o, mon_w);
        end
      end else begin
        check("bubble_hold", data_o, prev_data);
      end
      prev_data = data_o;
      if (exp_seq == 32) begin
        exp_seq = 0;
      end else if (valid_i) begin
        mon_b = {data_i, head_i};
        for (int i = 0; i < 66; i++) sb_q.push_back(mon_b[i]);
        exp_seq++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_block(input logic [1:0] h, input logic [63:0] d);
    bit acc = 1'b0;
    valid_i = 1'b1;
    head_i  = h;
    data_i  = d;
    for (int t = 0; t < 3 && !acc; t++) begin
      acc = ready_o;
      tick();
    end
    if (!acc) begin
      n_total++;
      $display("FAIL accept_timeout: ready_o got 0 for 3 cycles, required 1");
    end
  endtask

  task automatic bubble();
    valid_i = 1'b0;
    tick();
  endtask

  task automatic reset_pulse();
    tick();
    valid_i = 1'b0;
    nreset  = 1'b0;
    tick();
    nreset  = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  h1;
    logic [63:0] d1;
    logic [1:0]  h2;
    logic [63:0] d2;
    logic [63:0] e1;
    logic [63:0] e2;
  } vec_t;

  vec_t        vecs[6];
  logic [63:0] held;
  logic [63:0] x_data;
  logic [7:0]  kb;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0].h1 = 2'b01; vecs[0].d1 = 64'h0123_4567_89AB_CDEF;
    vecs[0].h2 = 2'b10; vecs[0].d2 = 64'hFEDC_BA98_7654_3210;
    vecs[1].h1 = 2'b10; vecs[1].d1 = 64'hFFFF_FFFF_FFFF_FFFF;
    vecs[1].h2 = 2'b01; vecs[1].d2 = 64'h0000_0000_0000_0000;
    vecs[2].h1 = 2'b01; vecs[2].d1 = 64'h0000_0000_0000_0000;
    vecs[2].h2 = 2'b01; vecs[2].d2 = 64'hFFFF_FFFF_FFFF_FFFF;
    vecs[3].h1 = 2'b10; vecs[3].d1 = 64'h8000_0000_0000_0001;
    vecs[3].h2 = 2'b10; vecs[3].d2 = 64'h4000_0000_0000_0002;
    vecs[4].h1 = 2'b01; vecs[4].d1 = 64'hC000_0000_0000_0000;
    vecs[4].h2 = 2'b10; vecs[4].d2 = 64'hA5A5_5A5A_F0F0_0F0F;
    vecs[5].h1 = 2'b10; vecs[5].d1 = 64'h4000_0000_DEAD_BEEF;
    vecs[5].h2 = 2'b01; vecs[5].d2 = 64'h1234_5678_9ABC_DEF0;
    // First word carries header then the low 62 payload bits; the second leads with the 2-bit residual.
    for (int i = 0; i < 6; i++) begin
      vecs[i].e1 = {vecs[i].d1[61:0], vecs[i].h1};
      vecs[i].e2 = {vecs[i].d2[59:0], vecs[i].h2, vecs[i].d1[63:62]};
    end

    tick();
    tick();
    nreset = 1'b1;
    check("reset_ready", 64'(ready_o), 64'd1);
    check("reset_valid", 64'(valid_o), 64'd0);
    check("reset_data", data_o, 64'd0);
    check("reset_seq", 64'(seq_o), 64'd0);

    for (int i = 0; i < 6; i++) begin
      reset_pulse();
      drive_block(vecs[i].h1, vecs[i].d1);
      check("vec_word1", data_o, vecs[i].e1);
      check("vec_valid1", 64'(valid_o), 64'd1);
      check("vec_seq1", 64'(seq_o), 64'd1);
      drive_block(vecs[i].h2, vecs[i].d2);
      check("vec_word2", data_o, vecs[i].e2);
      check("vec_seq2", 64'(seq_o), 64'd2);
      valid_i = 1'b0;
    end

    reset_pulse();
    for (int k = 0; k < 32; k++) begin
      kb = k[7:0];
      drive_block(2'b10, {8{kb}});
    end
    check("full_seq32", 64'(seq_o), 64'd32);
    check("full_ready_low", 64'(ready_o), 64'd0);
    x_data  = 64'hA1B2_C3D4_E5F6_0718;
    valid_i = 1'b1;
    head_i  = 2'b01;
    data_i  = x_data;
    tick();
    check("flush_word", data_o, 64'h1F1F_1F1F_1F1F_1F1F);
    check("flush_valid", 64'(valid_o), 64'd1);
    check("flush_seq0", 64'(seq_o), 64'd0);
    tick();
    check("offer_x_word", data_o, {x_data[61:0], 2'b01});
    check("offer_x_seq", 64'(seq_o), 64'd1);
    valid_i = 1'b0;

    reset_pulse();
    for (int k = 0; k < 9; k++) drive_block(2'($urandom_range(1, 2)), {$urandom, $urandom});
    check("bubble_seq9", 64'(seq_o), 64'd9);
    held = data_o;
    for (int b = 0; b < 3; b++) begin
      bubble();
      check("bubble_valid", 64'(valid_o), 64'd0);
      check("bubble_seq", 64'(seq_o), 64'd9);
      check("bubble_data", data_o, held);
    end
    for (int k = 0; k < 30; k++) drive_block(2'($urandom_range(1, 2)), {$urandom, $urandom});
    valid_i = 1'b0;

    reset_pulse();
    for (int k = 0; k < 17; k++) drive_block(2'b01, {$urandom, $urandom});
    check("mid_seq17", 64'(seq_o), 64'd17);
    #2;
    nreset = 1'b0;
    valid_i = 1'b0;
    #1;
    check("mid_rst_ready", 64'(ready_o), 64'd1);
    check("mid_rst_valid", 64'(valid_o), 64'd0);
    check("mid_rst_data", data_o, 64'd0);
    check("mid_rst_seq", 64'(seq_o), 64'd0);
    tick();
    nreset = 1'b1;
    tick();
    check("mid_rel_seq", 64'(seq_o), 64'd0);

    for (int k = 0; k < 1000; k++) begin
      while ($urandom_range(99) < 30) bubble();
      drive_block(2'($urandom_range(1, 2)), {$urandom, $urandom});
    end
    valid_i = 1'b0;
    for (int k = 0; k < 40; k++) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pcs_10g_gearbox_tx.md
# pcs_10g_gearbox_tx

Transmit gearbox that sits directly downstream of the 10GBASE-R PCS encode/scramble path. Each cycle it takes one 66-bit block, a 2-bit sync header plus a 64-bit payload, and packs the blocks into a continuous 64-bit word stream for the PMA serializer. Because 33 output words carry exactly 32 blocks, the gearbox drops `ready_o` for one cycle in every 33 to flush its residual buffer.

## Interface
- `DATA_W`, 64: payload and output word width.
- `HEAD_W`, 2: sync header width.
- `SEQ_W`, 6: width of the sequence counter, which counts 0..32.

- `clk`  in  1  single clock.
- `nreset`  in  1  asynchronous, active-low reset.
- `valid_i`  in  1  block present on `head_i`/`data_i`.
- `head_i`  in  2  sync header. `2'b01` is data, `2'b10` is control. Transmitted first.
- `data_i`  in  64  block payload (already scrambled). Bit 0 is transmitted first.
- `ready_o`  out  1  gearbox accepts a block this cycle.
- `valid_o`  out  1  `data_o` holds a valid PMA word.
- `data_o`  out  64  PMA word. Bit 0 is transmitted first.
- `seq_o`  out  6  current sequence count, for debug and PMA alignment.

## Operation
- Serial order of one block: `b = {data_i, head_i}` (66 bits), sent LSB first.
- State:
  - `seq_q`, 0..32.
  - Residual buffer `buf_q`, 64 bits. The low `2*seq_q` bits are valid; the remaining bits are don't-care and are driven to 0.
- `ready_o = (seq_q != 32)`. It is combinational from registered state only and never depends on `valid_i`.
- Transfer: the gearbox accepts a block when `valid_i & ready_o`. With `r = 2*seq_q`:
  - Form the 130-bit value `cat = {b, buf_q[r-1:0]}`, with residual bits at the LSBs. The effective width is `r + 66`.
  - `data_o <= cat[63:0]`.
  - `buf_q <= cat[r+65:64]`, zero-extended.
  - `seq_q <= seq_q + 1`.
  - `valid_o <= 1`.
- Flush: when `seq_q == 32`, the buffer holds exactly 64 bits.
  - `data_o <= buf_q`, `valid_o <= 1`.
  - `buf_q <= 0`, `seq_q <= 0`.
  - `valid_i` is ignored in this cycle, and any block offered is not consumed.
- Bubble: when `seq_q < 32` and `valid_i == 0`:
  - `valid_o <= 0`.
  - `data_o` holds its previous value.
  - `seq_q` and `buf_q` are unchanged.
  - The word stream is paused, not corrupted.
- Width rule: the `cat` selection is a barrel shift by `r` over the 0..62 even-step range. No other shift amounts occur.
- State machine, encoded by `seq_q`:
  - FILL (0..31): transfers only.
  - FLUSH (32): unconditional one-cycle state that returns to FILL(0).

## Timing
- Reset (asynchronous assert, synchronous to `clk` on release) sets: `seq_q = 0`, `buf_q = 0`, `data_o = 0`, `valid_o = 0`, `seq_o = 0`. Consequently `ready_o = 1`.
- Latency: 1 cycle from accepted block to its first bits on `data_o`. All outputs except `ready_o` are registered.
- Throughput: 32 blocks per 33 cycles under continuous `valid_i`. `ready_o` is low in exactly cycle 33 of each period.
- Upstream must hold a block while `ready_o == 0`. The gearbox never drops an accepted block.
- Reset asserted mid-sequence discards the residual immediately. Outputs return to their reset values asynchronously.
- `seq_o` wraps from 32 to 0. No state other than 0..32 is reachable. An out-of-range value (formal/X only) is treated as FLUSH.

## Test plan
- Reset: hold `nreset = 0`, then release. Required: `ready_o = 1`, `valid_o = 0`, `data_o = 0`, `seq_o = 0`. Then apply reset mid-sequence at `seq_o = 17`: all outputs return to reset values within the same cycle and `seq_o = 0` after release.
- Single block: `head_i = 2'b01`, `data_i = 64'h0123_4567_89AB_CDEF`, `valid_i = 1`. Required, next cycle: `valid_o = 1`, `data_o = {data_i[61:0], 2'b01}`, `seq_o = 1`, `buf_q[1:0] = data_i[63:62]`.
- Full period: send 32 consecutive blocks, where block `k` has `head = 2'b10` and `data = {8{k[7:0]}}`.
  - `ready_o` drops exactly when `seq_o = 32`.
  - The flush word equals block 31's `data_i`, `64'h1F1F_1F1F_1F1F_1F1F`.
  - A reference model serialising all 32×66 bits matches the 33 concatenated output words bit-exactly.
- Offer during flush: assert `valid_i` with block X while `ready_o = 0`. Required: X is not consumed. X, still held, is accepted in the next cycle at `seq_o = 0` and appears as `data_o = {X.data[61:0], X.head}`.
- Bubbles: deassert `valid_i` for 3 cycles at `seq_o = 9`. Required: `valid_o = 0` for 3 cycles, `seq_o` stays 9, `data_o` is held. After resuming, the serial stream is identical to the no-bubble reference.
- Sustained traffic: run 1000 random blocks with random `valid_i` at 70% duty. Required: the scoreboard of bit-serial order matches, and `ready_o` is low only at `seq_o = 32`.
